xadc_scan_scheduler: RTL and testbench
======================================

Name: xadc_scan_scheduler

Overview:
- Sequences XADC DRP reads of the auxiliary analog channels (VAUX0..3) that carry the neuromorphic ASIC's analog neuron outputs.
- Captures each 12-bit conversion, thresholds it into a spike vector and selects a winning output neuron (digit class).
- Publishes all results atomically to the AXI-lite register block.
- Sits between the XADC primitive's DRP port and the bridge register file; one instance per bridge top.

Parameters:
- NUM_CH, 4: number of VAUX channels scanned (1..16).
- CH_W, 2: width of the winner index; equals clog2(NUM_CH), minimum 1.
- DRP_BASE, 7'h10: DRP status address of VAUX0; channel n is read at DRP_BASE+n.
- DATA_W, 12: conversion width, taken from drp_do[15:4].
- TIMEOUT, 64: maximum cycles to wait for drp_drdy before abandoning a read.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scans allowed when high.
- ch_mask  in  NUM_CH  per-channel scan enable.
- threshold  in  DATA_W  spike threshold.
- period  in  16  minimum cycles between scan starts.
- err_clr  in  1  clears timeout_err.
- xadc_eoc  in  1  XADC end-of-conversion pulse.
- drp_den  out  1  DRP enable, 1-cycle pulse.
- drp_dwe  out  1  tied 0; reads only.
- drp_daddr  out  7  DRP address.
- drp_drdy  in  1  DRP data ready.
- drp_do  in  16  DRP read data.
- samples  out  NUM_CH*DATA_W  channel n occupies bits [n*DATA_W +: DATA_W].
- spikes  out  NUM_CH  bit n = samples[n] >= threshold.
- winner  out  CH_W  index of the largest enabled sample.
- scan_done  out  1  1-cycle pulse when outputs update.
- busy  out  1  high from ARM through FINISH.
- timeout_err  out  1  sticky DRP timeout flag.

Behaviour:
- Reset (sync, active-high) values: all outputs 0, state IDLE, period counter 0, shadow samples 0.
- A reset asserted mid-scan aborts the scan: drp_den is low from the next cycle and no scan_done pulse is produced.
- Period counter: increments every cycle while in IDLE and saturates at period. It clears when a scan starts. period=0 means scans run back-to-back.
- IDLE -> ARM when enable=1, counter>=period and ch_mask!=0. ch_mask is latched at this transition and later changes are ignored until the next scan.
- ARM: waits for xadc_eoc=1, then loads the lowest enabled channel index and moves to REQ.
- REQ: drp_den=1 for exactly one cycle with drp_daddr=DRP_BASE+ch, then WAIT. drp_daddr holds its value through WAIT.
- WAIT, drp_drdy=1: shadow[ch] <= drp_do[15:4], go to NEXT.
- WAIT, TIMEOUT cycles elapse without drdy: shadow[ch] keeps its old value, timeout_err <= 1, go to NEXT.
- A drdy that arrives on the same cycle as the timeout counts as data, not as a timeout.
- drp_drdy in any state other than WAIT is ignored.
- NEXT: selects the next-higher enabled channel and goes to REQ, otherwise goes to FINISH. Masked channels are never read and their shadow holds.
- FINISH, single cycle, outputs registered:
  - samples <= shadow;
  - spikes[n] <= latched_mask[n] & (shadow[n] >= threshold), unsigned compare;
  - winner <= index of the maximum shadow over latched_mask, lowest index on ties;
  - scan_done=1; then IDLE.
- Outputs change only at FINISH, so the register file never sees a partial scan.
- Latency with drdy immediate: ARM exit to scan_done = 3*k+1 cycles for k enabled channels.
- If enable deasserts mid-scan, the current scan completes; the block then stays in IDLE.
- timeout_err: if err_clr and a new timeout occur on the same cycle, set wins. err_clr otherwise clears the flag on the next edge.
- busy = 1 in ARM, REQ, WAIT, NEXT and FINISH.

Decomposition:
- Shared package xadc_scan_pkg holds:
  - state encoding (IDLE, ARM, REQ, WAIT, NEXT, FINISH);
  - DRP_VAUX0_ADDR = 7'h10;
  - XADC data-field offset 4;
  - default TIMEOUT.
- One natural sub-module, xadc_scan_argmax: a combinational max/argmax tree over the masked shadow samples with lowest-index tie-break. It is reused for winner and is unit-testable on its own.

Test Plan:
- Single channel: ch_mask=4'b0001, threshold=12'h800, period=0, eoc pulse, drdy returns 16'hA5C0 two cycles after den -> one den at daddr=7'h10; samples[0]=12'hA5C; spikes=4'b0001; winner=0; scan_done one cycle.
- Full scan: ch_mask=4'hF, drp_do per channel 16'h1000, 16'hF000, 16'h8000, 16'hF000 -> daddr sequence 10,11,12,13; samples 100,F00,800,F00; threshold=12'h800 gives spikes=4'b1110; winner=1 (tie resolved to lowest index).
- Sparse mask: ch_mask=4'b1010 after a full scan -> only daddr 11 and 13 issued; samples[0] and samples[2] unchanged; scan_done after 7 cycles from ARM exit.
- Timeout: ch_mask=4'b0001, drdy never asserted -> after 64 WAIT cycles timeout_err=1, samples[0] held, scan_done still pulses; err_clr=1 -> timeout_err=0 next cycle.
- Period and enable: period=100, enable held high -> scan starts spaced by at least 100 IDLE cycles. enable dropped during WAIT -> that scan completes and no further den is issued.
- Reset mid-scan: rst=1 during WAIT -> next cycle state IDLE, all outputs 0, no scan_done; a late drdy is ignored.

Source files
------------

// File: rtl/xadc_scan_pkg.sv
// Shared encodings and constants for the XADC auxiliary-channel scan scheduler.
package xadc_scan_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_REQ    = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  localparam logic [6:0] DRP_VAUX0_ADDR = 7'h10;
  localparam int         XADC_DATA_LSB  = 4;
  localparam int         DEF_TIMEOUT    = 64;

endpackage

// File: rtl/xadc_scan_argmax.sv
// Combinational argmax over the masked channel samples; lowest index wins ties.
// Zero latency; no flow control.
module xadc_scan_argmax #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int DATA_W = 12
) (
  input  logic [NUM_CH*DATA_W-1:0] samples,
  input  logic [NUM_CH-1:0]        mask,
  output logic [CH_W-1:0]          idx
);

  logic [DATA_W-1:0] best;
  logic              found;

  // Strict greater-than keeps the earlier (lower) index on equal samples.
  always_comb begin
    idx   = '0;
    best  = '0;
    found = 1'b0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (mask[n] && (!found || samples[n*DATA_W +: DATA_W] > best)) begin
        found = 1'b1;
        best  = samples[n*DATA_W +: DATA_W];
        idx   = CH_W'(n);
      end
    end
  end

endmodule

// File: rtl/xadc_scan_scheduler.sv
// Scans enabled VAUX channels over the XADC DRP and publishes samples/spikes/winner at once.
// Latency 3k+1 cycles from eoc for k channels with immediate drdy; a missing drdy is abandoned after TIMEOUT.
module xadc_scan_scheduler
  import xadc_scan_pkg::*;
#(
  parameter int         NUM_CH   = 4,
  parameter int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter logic [6:0] DRP_BASE = DRP_VAUX0_ADDR,
  parameter int         DATA_W   = 12,
  parameter int         TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [DATA_W-1:0]        threshold,
  input  logic [15:0]              period,
  input  logic                     err_clr,
  input  logic                     xadc_eoc,
  output logic                     drp_den,
  output logic                     drp_dwe,
  output logic [6:0]               drp_daddr,
  input  logic                     drp_drdy,
  input  logic [15:0]              drp_do,
  output logic [NUM_CH*DATA_W-1:0] samples,
  output logic [NUM_CH-1:0]        spikes,
  output logic [CH_W-1:0]          winner,
  output logic                     scan_done,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [2:0]               state;
  logic [NUM_CH-1:0]        mask_q;
  logic [CH_W-1:0]          ch_q;
  logic [15:0]              pcnt;
  logic [TO_W-1:0]          wcnt;
  logic [NUM_CH*DATA_W-1:0] shadow;

  logic [CH_W-1:0]          first_ch;
  logic [CH_W-1:0]          next_ch;
  logic                     has_next;
  logic [CH_W-1:0]          argmax_idx;
  logic [NUM_CH-1:0]        spikes_nxt;
  logic                     to_hit;
  logic                     unused_lsbs;

  assign unused_lsbs = ^drp_do[XADC_DATA_LSB-1:0];

  assign drp_den = (state == ST_REQ);
  assign drp_dwe = 1'b0;
  assign busy    = (state != ST_IDLE);

  // Descending walk so the lowest qualifying channel is the one left standing.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (mask_q[n]) begin
        first_ch = CH_W'(n);
      end
      if (mask_q[n] && (n > int'(ch_q))) begin
        has_next = 1'b1;
        next_ch  = CH_W'(n);
      end
    end
  end

  always_comb begin
    spikes_nxt = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      spikes_nxt[n] = mask_q[n] && (shadow[n*DATA_W +: DATA_W] >= threshold);
    end
  end

  // A drdy on the final wait cycle is data, so it suppresses the timeout.
  assign to_hit = (state == ST_WAIT) && !drp_drdy && (wcnt == TO_W'(TIMEOUT - 1));

  xadc_scan_argmax #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .DATA_W (DATA_W)
  ) u_argmax (
    .samples (shadow),
    .mask    (mask_q),
    .idx     (argmax_idx)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) begin
      state       <= ST_IDLE;
      mask_q      <= '0;
      ch_q        <= '0;
      pcnt        <= '0;
      wcnt        <= '0;
      shadow      <= '0;
      drp_daddr   <= '0;
      samples     <= '0;
      spikes      <= '0;
      winner      <= '0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      scan_done <= 1'b0;

      if (to_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pcnt < period) begin
            pcnt <= pcnt + 16'd1;
          end
          if (enable && (pcnt >= period) && (|ch_mask)) begin
            mask_q <= ch_mask;
            pcnt   <= '0;
            state  <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (xadc_eoc) begin
            ch_q      <= first_ch;
            drp_daddr <= DRP_BASE + 7'(first_ch);
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          wcnt  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (drp_drdy) begin
            shadow[int'(ch_q)*DATA_W +: DATA_W] <= drp_do[XADC_DATA_LSB +: DATA_W];
            state <= ST_NEXT;
          end else if (to_hit) begin
            state <= ST_NEXT;
          end else begin
            wcnt <= wcnt + TO_W'(1);
          end
        end
        ST_NEXT: begin
          if (has_next) begin
            ch_q      <= next_ch;
            drp_daddr <= DRP_BASE + 7'(next_ch);
            state     <= ST_REQ;
          end else begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          samples   <= shadow;
          spikes    <= spikes_nxt;
          winner    <= argmax_idx;
          scan_done <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_scan_scheduler.sv
// Bench for xadc_scan_scheduler: DRP responder, behavioural result model checked every cycle,
// plus directed scans with hand-computed latencies and literal results.
module tb_xadc_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  ch_mask = 4'h0;
  logic [11:0] threshold = 12'h000;
  logic [15:0] period = 16'd0;
  logic        err_clr = 1'b0;
  logic        xadc_eoc = 1'b0;
  logic        drp_drdy = 1'b0;
  logic [15:0] drp_do = 16'h0000;

  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic [47:0] samples;
  logic [3:0]  spikes;
  logic [1:0]  winner;
  logic        scan_done;
  logic        busy;
  logic        timeout_err;

  always #5 clk = ~clk;

  xadc_scan_scheduler dut (
    .S_AXI_ACLK  (clk),
    .rst         (rst),
    .enable      (enable),
    .ch_mask     (ch_mask),
    .threshold   (threshold),
    .period      (period),
    .err_clr     (err_clr),
    .xadc_eoc    (xadc_eoc),
    .drp_den     (drp_den),
    .drp_dwe     (drp_dwe),
    .drp_daddr   (drp_daddr),
    .drp_drdy    (drp_drdy),
    .drp_do      (drp_do),
    .samples     (samples),
    .spikes      (spikes),
    .winner      (winner),
    .scan_done   (scan_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rst_seen = 1'b0;
  logic clr_seen = 1'b0;

  // Model: per-channel data the DRP returns, what the block has captured, and what it published.
  logic [15:0] ch_data[4];
  int          ch_delay[4];
  logic [11:0] m_shadow[4];
  logic [11:0] p_samples[4];
  logic [3:0]  p_spikes = 4'h0;
  int          p_winner = 0;
  logic        m_terr = 1'b0;
  logic [3:0]  scan_mask = 4'h0;
  int          exp_ch_q[$];
  int          rsp_cnt = -1;
  int          rsp_ch = 0;
  int          to_cnt = -1;
  logic        rsp_live = 1'b0;
  int          den_cnt = 0;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic publish();
    int best;
    best = -1;
    for (int n = 0; n < 4; n++) begin
      p_samples[n] = m_shadow[n];
      p_spikes[n]  = scan_mask[n] && (m_shadow[n] >= threshold);
      if (scan_mask[n] && (best < 0 || m_shadow[n] > m_shadow[best])) best = n;
    end
    p_winner = (best < 0) ? 0 : best;
  endtask

  task automatic fire();
    drp_drdy = 1'b1;
    drp_do   = ch_data[rsp_ch];
    if (rsp_live) m_shadow[rsp_ch] = drp_do[15:4];
    rsp_live = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_seen = rst;
    clr_seen = err_clr;
  end

  // Responder plus per-cycle comparison against the model.
  always @(negedge clk) begin
    logic set_now;
    if (cyc > 0) begin
      if (rst_seen) begin
        for (int n = 0; n < 4; n++) begin
          m_shadow[n] = 12'h000;
          p_samples[n] = 12'h000;
        end
        p_spikes = 4'h0;
        p_winner = 0;
        m_terr = 1'b0;
        exp_ch_q.delete();
        rsp_live = 1'b0;
        to_cnt = -1;
      end else begin
        set_now = 1'b0;
        if (to_cnt > 0) begin
          to_cnt--;
          if (to_cnt == 0) set_now = 1'b1;
        end
        if (set_now) m_terr = 1'b1;
        else if (clr_seen) m_terr = 1'b0;
        if (scan_done) begin
          publish();
          done_cnt++;
        end
      end

      drp_drdy = 1'b0;
      if (rsp_cnt == 0) begin
        fire();
        rsp_cnt = -1;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
      end

      if (drp_den) begin
        den_cnt++;
        if (exp_ch_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_den: daddr %0h issued, none expected", drp_daddr);
        end else begin
          rsp_ch = exp_ch_q.pop_front();
          chk("den_daddr", drp_daddr, 7'h10 + rsp_ch);
          rsp_live = 1'b1;
          if (ch_delay[rsp_ch] < 0) to_cnt = 65;
          else rsp_cnt = ch_delay[rsp_ch];
        end
      end

      chk("samples", samples, {p_samples[3], p_samples[2], p_samples[1], p_samples[0]});
      chk("spikes", spikes, p_spikes);
      chk("winner", winner, p_winner);
      chk("timeout_err", timeout_err, m_terr);
      chk("drp_dwe", drp_dwe, 0);
      chk("den_only_when_busy", drp_den & ~busy, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input string name, input logic [3:0] m, input int exp_lat);
    int w;
    int c0;
    ch_mask = m;
    scan_mask = m;
    for (int n = 0; n < 4; n++) if (m[n]) exp_ch_q.push_back(n);
    enable = 1'b1;
    w = 0;
    while (!busy && w < 400) begin tick(); w++; end
    chk({name, "_start"}, busy, 1);
    enable = 1'b0;
    ch_mask = ~m;
    tick();
    chk({name, "_arm_waits_eoc"}, drp_den, 0);
    xadc_eoc = 1'b1;
    c0 = cyc;
    tick();
    xadc_eoc = 1'b0;
    w = 0;
    while (!scan_done && w < 500) begin tick(); w++; end
    chk({name, "_done_seen"}, scan_done, 1);
    chk({name, "_latency"}, cyc - c0 - 1, exp_lat);
    chk({name, "_reads_issued"}, exp_ch_q.size(), 0);
  endtask

  initial begin
    int dc;
    int w;
    int d_prev;
    int gap;
    for (int n = 0; n < 4; n++) begin
      ch_data[n] = 16'h0000;
      ch_delay[n] = 0;
      m_shadow[n] = 12'h000;
      p_samples[n] = 12'h000;
    end

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_samples", samples, 0);
    chk("rst_spikes", spikes, 0);
    chk("rst_winner", winner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_den", drp_den, 0);
    chk("rst_daddr", drp_daddr, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;
    tick();

    // Single channel, drdy two cycles after den.
    threshold = 12'h800;
    period = 16'd0;
    ch_data[0] = 16'hA5C0;
    ch_delay[0] = 1;
    dc = den_cnt;
    run_scan("single", 4'b0001, 5);
    chk("single_den_count", den_cnt - dc, 1);
    chk("single_samples", samples, 48'h000000000A5C);
    chk("single_spikes", spikes, 4'b0001);
    chk("single_winner", winner, 0);
    chk("single_idle_at_done", busy, 0);
    tick();
    chk("single_done_pulse_width", scan_done, 0);

    // Full scan with a tie between channels 1 and 3.
    ch_data[0] = 16'h1000; ch_data[1] = 16'hF000; ch_data[2] = 16'h8000; ch_data[3] = 16'hF000;
    for (int n = 0; n < 4; n++) ch_delay[n] = 0;
    run_scan("full", 4'hF, 13);
    chk("full_samples", samples, 48'hF00800F00100);
    chk("full_spikes", spikes, 4'b1110);
    chk("full_winner", winner, 1);
    tick();

    // Sparse mask; masked channels hold, equality meets threshold, masked max ignored.
    threshold = 12'h300;
    ch_data[1] = 16'h3000; ch_data[3] = 16'h7000;
    run_scan("sparse", 4'b1010, 7);
    chk("sparse_samples", samples, 48'h700800300100);
    chk("sparse_spikes", spikes, 4'b1010);
    chk("sparse_winner", winner, 3);
    tick();

    // Timeout: no drdy at all.
    ch_delay[0] = -1;
    run_scan("timeout", 4'b0001, 67);
    chk("timeout_flag", timeout_err, 1);
    chk("timeout_sample_held", samples[11:0], 12'h100);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("timeout_cleared", timeout_err, 0);

    // err_clr held across a new timeout: set wins for one cycle, then clear.
    err_clr = 1'b1;
    run_scan("setwins", 4'b0001, 67);
    chk("setwins_cleared_later", timeout_err, 0);
    err_clr = 1'b0;
    tick();

    // drdy on the last permitted wait cycle is data.
    ch_data[0] = 16'h2220;
    ch_delay[0] = 63;
    run_scan("drdy_at_limit", 4'b0001, 67);
    chk("limit_no_timeout", timeout_err, 0);
    chk("limit_sample", samples[11:0], 12'h222);
    tick();

    // Period spacing with enable held, then enable dropped mid-scan.
    period = 16'd100;
    ch_mask = 4'b0001;
    scan_mask = 4'b0001;
    ch_data[0] = 16'h1230;
    ch_delay[0] = 0;
    enable = 1'b1;
    d_prev = 0;
    for (int s = 0; s < 2; s++) begin
      exp_ch_q.push_back(0);
      w = 0;
      while (!busy && w < 400) begin tick(); w++; end
      chk("period_start", busy, 1);
      if (s == 1) begin
        gap = cyc - d_prev;
        chk("period_idle_gap", gap, 101);
      end
      xadc_eoc = 1'b1;
      tick();
      xadc_eoc = 1'b0;
      if (s == 1) begin
        tick();
        enable = 1'b0;
      end
      w = 0;
      while (!scan_done && w < 500) begin tick(); w++; end
      chk("period_done_seen", scan_done, 1);
      d_prev = cyc;
    end
    dc = den_cnt;
    repeat (150) tick();
    chk("enable_drop_idle", busy, 0);
    chk("enable_drop_no_den", den_cnt - dc, 0);

    // Reset during WAIT with a late drdy afterwards.
    period = 16'd0;
    ch_data[0] = 16'h9990;
    ch_delay[0] = 5;
    ch_mask = 4'b0001;
    scan_mask = 4'b0001;
    exp_ch_q.push_back(0);
    enable = 1'b1;
    w = 0;
    while (!busy && w < 400) begin tick(); w++; end
    enable = 1'b0;
    xadc_eoc = 1'b1;
    tick();
    xadc_eoc = 1'b0;
    tick();
    rst = 1'b1;
    dc = done_cnt;
    tick();
    rst = 1'b0;
    chk("midrst_samples", samples, 0);
    chk("midrst_spikes", spikes, 0);
    chk("midrst_winner", winner, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_den", drp_den, 0);
    chk("midrst_done", scan_done, 0);
    chk("midrst_terr", timeout_err, 0);
    repeat (10) tick();
    chk("midrst_no_done", done_cnt - dc, 0);
    chk("midrst_late_drdy_ignored", samples, 0);

    // Fresh scan after reset: other channels stay cleared.
    threshold = 12'h800;
    ch_data[0] = 16'h4560;
    ch_delay[0] = 0;
    run_scan("post_rst", 4'b0001, 4);
    chk("post_rst_samples", samples, 48'h000000000456);
    chk("post_rst_spikes", spikes, 4'b0000);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
